core2_op_dispatcher: RTL and testbench
======================================

// Module: core2_op_dispatcher
// PURPOSE
//  Upstream feeder for the Core2 FIFO wrapper. Accepts host operation requests (A, B, opcode) on a
//  valid/ready handshake. Writes operands and command into the Core2 input and command FIFOs in the
//  same cycle, so the two FIFOs never skew. Limits in-flight ops to the output-FIFO depth with a credit counter.
// PARAMETERS
//  DATA_W           128  width of each operand (A, B)
//  OP_W             3    opcode width (Core2 select line)
//  CMD_W            4    command FIFO word width; cmd = {1'b0, op}
//  MAX_OUTSTANDING  8    max ops issued but not yet popped from the output FIFO
//  CNT_W            4    outstanding counter width; must hold MAX_OUTSTANDING
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  s_valid         in   1       host request valid
//  s_ready         out  1       dispatcher can accept this cycle
//  s_a             in   DATA_W  operand A
//  s_b             in   DATA_W  operand B
//  s_op            in   OP_W    Core2 opcode
//  wr_en_inp       out  1       write strobe to Core2 input FIFO
//  data_a          out  DATA_W  operand A to input FIFO
//  data_b          out  DATA_W  operand B to input FIFO
//  in_busy_inp     in   1       input FIFO full
//  wr_en_cmd       out  1       write strobe to Core2 command FIFO
//  data_cmd        out  CMD_W   command word
//  in_busy_cmd     in   1       command FIFO full
//  res_pop         in   1       host read one result from the output FIFO (returns one credit)
//  outstanding     out  CNT_W   ops in flight
//  idle            out  1       no held request and outstanding==0
//  err_underflow   out  1       sticky: res_pop seen while outstanding==0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=EMPTY. wr_en_inp=wr_en_cmd=0, data_*=0,
//    outstanding=0, err_*=0, idle=1. A held request is discarded.
//  - Request register states: EMPTY, HELD.
//    EMPTY: s_valid&&s_ready captures s_a/s_b/s_op -> HELD.
//    HELD: issue when !in_busy_inp && !in_busy_cmd && outstanding<MAX_OUTSTANDING.
//  - Issue: on the next edge, wr_en_inp=wr_en_cmd=1 for exactly one cycle, with data_* registered.
//    Both strobes are always equal. Never write one FIFO without the other.
//  - s_ready = (state==EMPTY) || issue. A new request is captured in the issue cycle, giving
//    1 op/cycle throughput. Latency from s_valid&&s_ready to the FIFO strobes is 2 cycles.
//  - Either busy flag asserted, or credits exhausted: hold the request, s_ready=0, no strobe.
//  - outstanding: +1 on issue, -1 on res_pop; both in the same cycle leaves it unchanged.
//    res_pop at 0: counter stays 0 and err_underflow sets. Cleared only by reset.
//  - The counter never exceeds MAX_OUTSTANDING, so no wrap-around is possible.
// CONFIGURATION
//  CORE2_DISP_ILLEGAL_OP_EN defined:
//   - s_op==3'b111 is accepted (s_ready obeyed) but never issued and never consumes a credit.
//   - Adds output err_illegal_op (sticky, reset 0).
//  Undefined: every opcode is forwarded unchanged and the port is absent.
// STRUCTURE
//  - core2_pkg: OP_W/CMD_W localparams, opcode constants (incl. OP_ILLEGAL=3'b111), the
//    EMPTY/HELD state encoding, and the cmd-word pack function.
//  - Sub-module core2_credit_counter: inc/dec/underflow, with outstanding and credit_avail outputs.
// TESTING
//  1. Single op A=1, B=2, op=3 with FIFOs free:
//     wr_en_inp=wr_en_cmd=1 exactly 2 cycles later, data_cmd=4'h3, outstanding=1.
//  2. 10 back-to-back requests, no res_pop: 8 issue on consecutive cycles, then s_ready=0,
//     outstanding=8. One res_pop -> exactly one more issue.
//  3. in_busy_cmd=1 for 5 cycles while HELD: no strobe on either FIFO. Issue the cycle after it drops.
//  4. res_pop in the same cycle as an issue at outstanding=3: outstanding stays 3.
//     res_pop at 0: err_underflow=1 and stays set.
//  5. rst_n low while HELD with outstanding=5: outputs reset immediately (async).
//     No strobe after release, idle=1.
//  6. With CORE2_DISP_ILLEGAL_OP_EN: op=7 gives no strobe and err_illegal_op=1.
//     Without the macro: op=7 issues data_cmd=4'h7.

Source files
------------

// File: rtl/core2_pkg.sv
// core2_pkg: shared widths, opcodes, request-register encoding and command-word packing
package core2_pkg;
  localparam int OP_W  = 3;
  localparam int CMD_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_XOR     = 3'b011,
    OP_ILLEGAL = 3'b111
  } op_e;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [OP_W-1:0] op);
    return {1'b0, op};
  endfunction
endpackage

// File: rtl/core2_credit_counter.sv
// core2_credit_counter: tracks ops in flight, flags a result pop with nothing outstanding
module core2_credit_counter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] outstanding,
  output logic             credit_avail,
  output logic             err_underflow
);
  logic uf, dn;
  assign uf = dec && outstanding == '0;
  assign dn = dec && !uf;
  assign credit_avail = outstanding < CNT_W'(MAX_OUTSTANDING);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding + CNT_W'(inc) - CNT_W'(dn);
      if (uf) err_underflow <= 1'b1;
    end
  end
endmodule

// File: rtl/core2_op_dispatcher.sv
// core2_op_dispatcher: feeds Core2 input/command FIFOs in lockstep under output-FIFO credits
// Optional CORE2_DISP_ILLEGAL_OP_EN: drop opcode 3'b111 and flag it on err_illegal_op.
module core2_op_dispatcher
  import core2_pkg::*;
#(
  parameter int DATA_W          = 128,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic [OP_W-1:0]   s_op,
  output logic              wr_en_inp,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              in_busy_inp,
  output logic              wr_en_cmd,
  output logic [CMD_W-1:0]  data_cmd,
  input  logic              in_busy_cmd,
  input  logic              res_pop,
  output logic [CNT_W-1:0]  outstanding,
  output logic              idle,
`ifdef CORE2_DISP_ILLEGAL_OP_EN
  output logic              err_illegal_op,
`endif
  output logic              err_underflow
);
  logic [0:0]        state;
  logic [DATA_W-1:0] hold_a, hold_b;
  logic [OP_W-1:0]   hold_op;
  logic              credit_avail, issue, drop, take, wr_en;
`ifdef CORE2_DISP_ILLEGAL_OP_EN
  assign drop = state == ST_HELD && hold_op == OP_ILLEGAL;
`else
  assign drop = 1'b0;
`endif
  assign issue = state == ST_HELD && !drop && !in_busy_inp && !in_busy_cmd && credit_avail;
  assign s_ready = state == ST_EMPTY || issue || drop;
  assign take = s_valid && s_ready;
  assign idle = state == ST_EMPTY && outstanding == '0;
  // one register drives both strobes so the FIFOs can never skew
  assign wr_en_inp = wr_en;
  assign wr_en_cmd = wr_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      hold_a   <= '0;
      hold_b   <= '0;
      hold_op  <= '0;
      wr_en    <= 1'b0;
      data_a   <= '0;
      data_b   <= '0;
      data_cmd <= '0;
    end else begin
      if (take) begin
        hold_a  <= s_a;
        hold_b  <= s_b;
        hold_op <= s_op;
      end
      state <= take ? ST_HELD : (issue || drop) ? ST_EMPTY : state;
      wr_en <= issue;
      if (issue) begin
        data_a   <= hold_a;
        data_b   <= hold_b;
        data_cmd <= pack_cmd(hold_op);
      end
    end
  end
`ifdef CORE2_DISP_ILLEGAL_OP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_illegal_op <= 1'b0;
    else if (drop) err_illegal_op <= 1'b1;
  end
`endif
  core2_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_credit (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (issue),
    .dec          (res_pop),
    .outstanding  (outstanding),
    .credit_avail (credit_avail),
    .err_underflow(err_underflow)
  );
endmodule

// File: tb/tb_core2_op_dispatcher.sv
// tb_core2_op_dispatcher: directed and random checks against an in-order scoreboard and credit model
module tb_core2_op_dispatcher;
  localparam int DW = 128;
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
  } req_t;
  logic          clk, rst_n, s_valid, s_ready, wr_en_inp, wr_en_cmd;
  logic          in_busy_inp, in_busy_cmd, res_pop, idle, err_underflow;
  logic [DW-1:0] s_a, s_b, data_a, data_b;
  logic [2:0]    s_op;
  logic [3:0]    data_cmd, outstanding;
`ifdef CORE2_DISP_ILLEGAL_OP_EN
  logic          err_illegal_op;
`endif
  req_t q[$];
  int tests = 0, fails = 0, model_out = 0, cyc = 0, strobes = 0;
  logic exp_uf = 1'b0, acc;
  core2_op_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_op(s_op),
    .wr_en_inp(wr_en_inp), .data_a(data_a), .data_b(data_b), .in_busy_inp(in_busy_inp),
    .wr_en_cmd(wr_en_cmd), .data_cmd(data_cmd), .in_busy_cmd(in_busy_cmd),
    .res_pop(res_pop), .outstanding(outstanding), .idle(idle),
`ifdef CORE2_DISP_ILLEGAL_OP_EN
    .err_illegal_op(err_illegal_op),
`endif
    .err_underflow(err_underflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic hs, bz, pe;
    req_t e;
    #1;
    hs = s_valid && s_ready;
    if (hs) begin
`ifdef CORE2_DISP_ILLEGAL_OP_EN
      if (s_op != 3'b111)
`endif
      q.push_back({s_a, s_b, s_op});
    end
    bz = in_busy_inp || in_busy_cmd;
    pe = res_pop && model_out > 0;
    if (res_pop && model_out == 0) exp_uf = 1'b1;
    acc = hs;
    @(posedge clk);
    #1;
    cyc++;
    model_out = model_out + int'(wr_en_inp) - int'(pe);
    check("strobe_pair", DW'(wr_en_cmd), DW'(wr_en_inp));
    check("strobe_while_busy", DW'(wr_en_inp && bz), DW'(0));
    if (wr_en_inp) begin
      strobes++;
      if (q.size() == 0) check("spurious_strobe", DW'(1), DW'(0));
      else begin
        e = q.pop_front();
        check("data_a", data_a, e.a);
        check("data_b", data_b, e.b);
        check("data_cmd", DW'(data_cmd), DW'({1'b0, e.op}));
      end
    end
    check("outstanding", DW'(outstanding), DW'(model_out));
    check("credit_cap", DW'(model_out <= 8), DW'(1));
    check("err_underflow", DW'(err_underflow), DW'(exp_uf));
  endtask
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_op = op;
  endtask
  task automatic drain();
    s_valid = 1'b0;
    in_busy_inp = 1'b0;
    in_busy_cmd = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      res_pop = outstanding != 0;
      tick();
    end
    res_pop = 1'b0;
    check("drain_idle", DW'(idle), DW'(1));
  endtask
  initial begin
    int sent, first, last, s0;
    logic seen;
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_op = '0;
    in_busy_inp = 1'b0; in_busy_cmd = 1'b0; res_pop = 1'b0;
    #3;
    check("rst_wr_en_inp", DW'(wr_en_inp), DW'(0));
    check("rst_wr_en_cmd", DW'(wr_en_cmd), DW'(0));
    check("rst_data_a", data_a, DW'(0));
    check("rst_data_cmd", DW'(data_cmd), DW'(0));
    check("rst_outstanding", DW'(outstanding), DW'(0));
    check("rst_err_underflow", DW'(err_underflow), DW'(0));
    check("rst_idle", DW'(idle), DW'(1));
    check("rst_s_ready", DW'(s_ready), DW'(1));
`ifdef CORE2_DISP_ILLEGAL_OP_EN
    check("rst_err_illegal", DW'(err_illegal_op), DW'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single op, strobe two cycles after the handshake
    send(DW'(1), DW'(2), 3'd3);
    tick();
    check("t1_accept", DW'(acc), DW'(1));
    s_valid = 1'b0;
    check("t1_no_early_strobe", DW'(wr_en_inp), DW'(0));
    tick();
    check("t1_wr_en_inp", DW'(wr_en_inp), DW'(1));
    check("t1_wr_en_cmd", DW'(wr_en_cmd), DW'(1));
    check("t1_cmd", DW'(data_cmd), DW'(4'h3));
    check("t1_outstanding", DW'(outstanding), DW'(1));
    tick();
    check("t1_one_cycle_strobe", DW'(wr_en_inp), DW'(0));
    drain();
    // 10 back-to-back requests against 8 credits
    sent = 0; seen = 1'b0; first = 0; last = 0; s0 = strobes;
    for (int c = 0; c < 12; c++) begin
      s_valid = sent < 10;
      s_a = DW'(sent + 100);
      s_b = DW'(sent + 200);
      s_op = 3'(sent);
      tick();
      if (acc) sent++;
      if (wr_en_inp) begin
        if (!seen) first = c;
        seen = 1'b1;
        last = c;
      end
    end
    check("t2_issued", DW'(strobes - s0), DW'(8));
    check("t2_consecutive", DW'(last - first), DW'(7));
    check("t2_accepted", DW'(sent), DW'(9));
    check("t2_outstanding", DW'(outstanding), DW'(8));
    check("t2_s_ready", DW'(s_ready), DW'(0));
    s0 = strobes;
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_valid = sent < 10;
      s_a = DW'(sent + 100);
      s_b = DW'(sent + 200);
      s_op = 3'(sent);
      tick();
      if (acc) sent++;
    end
    check("t2_one_more", DW'(strobes - s0), DW'(1));
    check("t2_accepted_all", DW'(sent), DW'(10));
    check("t2_outstanding_full", DW'(outstanding), DW'(8));
    drain();
    // command FIFO busy while a request is held
    in_busy_cmd = 1'b1;
    send(DW'(55), DW'(66), 3'd2);
    tick();
    s_valid = 1'b0;
    s0 = strobes;
    repeat (5) begin
      check("t3_hold_ready", DW'(s_ready), DW'(0));
      tick();
    end
    check("t3_no_strobe", DW'(strobes - s0), DW'(0));
    in_busy_cmd = 1'b0;
    tick();
    check("t3_issue_after_drop", DW'(wr_en_inp), DW'(1));
    drain();
    // simultaneous issue and pop at outstanding 3
    for (int i = 0; i < 4; i++) begin
      send(DW'(i + 10), DW'(i + 20), 3'(i));
      tick();
    end
    s_valid = 1'b0;
    check("t4_pre", DW'(outstanding), DW'(3));
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    check("t4_issue", DW'(wr_en_inp), DW'(1));
    check("t4_unchanged", DW'(outstanding), DW'(3));
    drain();
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    check("t4_underflow", DW'(err_underflow), DW'(1));
    check("t4_zero", DW'(outstanding), DW'(0));
    repeat (2) tick();
    check("t4_sticky", DW'(err_underflow), DW'(1));
    // async reset while holding with 5 in flight
    for (int i = 0; i < 6; i++) begin
      send(DW'(i + 30), DW'(i + 40), 3'(i));
      tick();
    end
    s_valid = 1'b0;
    in_busy_inp = 1'b1;
    tick();
    check("t5_outstanding", DW'(outstanding), DW'(5));
    check("t5_held", DW'(s_ready), DW'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_outstanding", DW'(outstanding), DW'(0));
    check("t5_async_idle", DW'(idle), DW'(1));
    check("t5_async_strobe", DW'(wr_en_inp), DW'(0));
    check("t5_async_data", data_a, DW'(0));
    check("t5_async_err", DW'(err_underflow), DW'(0));
    q.delete();
    model_out = 0;
    exp_uf = 1'b0;
    in_busy_inp = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = strobes;
    repeat (4) tick();
    check("t5_no_strobe", DW'(strobes - s0), DW'(0));
    check("t5_idle", DW'(idle), DW'(1));
    // opcode 7
    send(DW'(5), DW'(6), 3'd7);
    tick();
    s_valid = 1'b0;
    tick();
`ifdef CORE2_DISP_ILLEGAL_OP_EN
    tick();
    check("t6_no_strobe", DW'(wr_en_inp), DW'(0));
    check("t6_err_illegal", DW'(err_illegal_op), DW'(1));
    check("t6_no_credit", DW'(outstanding), DW'(0));
`else
    check("t6_strobe", DW'(wr_en_inp), DW'(1));
    check("t6_cmd", DW'(data_cmd), DW'(4'h7));
`endif
    drain();
    // random traffic against the scoreboard and credit model
    for (int c = 0; c < 500; c++) begin
      s_valid = $urandom_range(0, 3) != 0;
      s_a = {$urandom, $urandom, $urandom, $urandom};
      s_b = {$urandom, $urandom, $urandom, $urandom};
      s_op = 3'($urandom_range(0, 7));
      in_busy_inp = $urandom_range(0, 5) == 0;
      in_busy_cmd = $urandom_range(0, 5) == 0;
      res_pop = model_out > 0 && $urandom_range(0, 2) == 0;
      tick();
    end
    drain();
    check("rand_all_issued", DW'(q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
